// File: rtl/divide_ctrl_pkg.sv
// Shared defaults and FSM encoding for the divider sequencing stage.
package divide_ctrl_pkg;

    localparam int unsigned DEF_DATA_WD    = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_SETTLE_CYC = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/divide_ctrl_fifo_sync.sv
// Synchronous FIFO for operand pairs; full blocks pushes even when a pop is in the same cycle.
module divide_ctrl_fifo_sync #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_WD = $clog2(DEPTH);
    localparam int unsigned CNT_WD = PTR_WD + 1;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [PTR_WD-1:0] r_wr_ptr;
    logic [PTR_WD-1:0] r_rd_ptr;
    logic [CNT_WD-1:0] r_cnt;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_cnt == CNT_WD'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dat   = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_dat;
                r_wr_ptr        <= r_wr_ptr + PTR_WD'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_WD'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_WD'(1);
                2'b01:   r_cnt <= r_cnt - CNT_WD'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/divide_ctrl.sv
// Sequencing stage around a combinational divider: buffers operand pairs,
// holds them stable while the divider settles, and returns quotients in order.
module divide_ctrl
    import divide_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WD    = DEF_DATA_WD,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 val_i,
    output logic                 rdy_o,
    input  logic [DATA_WD-1:0]   dat_a_i,
    input  logic [DATA_WD-1:0]   dat_b_i,
    output logic [DATA_WD-1:0]   div_a_o,
    output logic [DATA_WD-1:0]   div_b_o,
    input  logic [2*DATA_WD-1:0] div_c_i,
    output logic                 val_o,
    input  logic                 rdy_i,
    output logic [2*DATA_WD-1:0] dat_c_o,
    output logic                 err_o
);

    localparam int unsigned QUOT_WD = 2 * DATA_WD;
    localparam int unsigned CNT_WD  = $clog2(SETTLE_CYC + 1);

    state_e               r_state;
    logic [CNT_WD-1:0]    r_cnt;
    logic [DATA_WD-1:0]   r_div_a;
    logic [DATA_WD-1:0]   r_div_b;
    logic [QUOT_WD-1:0]   r_dat_c;
    logic                 r_val;
    logic                 r_err;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_load;
    logic [QUOT_WD-1:0]   w_head;

    assign rdy_o  = ~w_full;
    assign w_load = ~w_empty & ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & rdy_i));

    divide_ctrl_fifo_sync #(
        .WIDTH (QUOT_WD),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (val_i & rdy_o),
        .i_pop   (w_load),
        .i_dat   ({dat_a_i, dat_b_i}),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Operands only move on a load, so the divider sees stable inputs through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_div_a <= '0;
            r_div_b <= '0;
            r_dat_c <= '0;
            r_val   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_div_a <= w_head[QUOT_WD-1 -: DATA_WD];
                        r_div_b <= w_head[DATA_WD-1:0];
                        r_cnt   <= CNT_WD'(SETTLE_CYC);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_WD'(1);
                    if (r_cnt == CNT_WD'(1)) begin
                        // A zero divisor saturates and flags; the divider output is meaningless then.
                        if (r_div_b == '0) begin
                            r_dat_c <= '1;
                            r_err   <= 1'b1;
                        end else begin
                            r_dat_c <= div_c_i;
                            r_err   <= 1'b0;
                        end
                        r_val   <= 1'b1;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (rdy_i) begin
                        r_val <= 1'b0;
                        if (w_load) begin
                            r_div_a <= w_head[QUOT_WD-1 -: DATA_WD];
                            r_div_b <= w_head[DATA_WD-1:0];
                            r_cnt   <= CNT_WD'(SETTLE_CYC);
                            r_state <= ST_WAIT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign div_a_o = r_div_a;
    assign div_b_o = r_div_b;
    assign dat_c_o = r_dat_c;
    assign val_o   = r_val;
    assign err_o   = r_err;

endmodule

// File: tb/tb_divide_ctrl.sv
// Scoreboard bench for divide_ctrl with a behavioural stand-in for the divider.
module tb_divide_ctrl;

    typedef struct {
        logic [15:0] quot;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        val_i = 1'b0;
    logic        rdy_o;
    logic [7:0]  dat_a_i = 8'd0;
    logic [7:0]  dat_b_i = 8'd0;
    logic [7:0]  div_a_o;
    logic [7:0]  div_b_o;
    logic [15:0] div_c_i;
    logic        val_o;
    logic        rdy_i = 1'b1;
    logic [15:0] dat_c_o;
    logic        err_o;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    bit   push_done;

    always #5 clk = ~clk;

    divide_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .val_i   (val_i),
        .rdy_o   (rdy_o),
        .dat_a_i (dat_a_i),
        .dat_b_i (dat_b_i),
        .div_a_o (div_a_o),
        .div_b_o (div_b_o),
        .div_c_i (div_c_i),
        .val_o   (val_o),
        .rdy_i   (rdy_i),
        .dat_c_o (dat_c_o),
        .err_o   (err_o)
    );

    // Exact rounding divider; drives junk for a zero divisor so ignoring it is observable.
    always_comb begin
        div_c_i = 16'hA5C3;
        if (div_b_o != 8'd0)
            div_c_i = 16'((32'(div_a_o) * 32'd256 + 32'(div_b_o) / 32'd2) / 32'(div_b_o));
    end

    function automatic exp_t ref_div(input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        int unsigned n;
        n = 32'(a) * 32'd256;
        if (b == 8'd0) begin
            e.quot = 16'hFFFF;
            e.err  = 1'b1;
        end else begin
            e.quot = 16'((2 * n + 32'(b)) / (2 * 32'(b)));
            e.err  = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented result with the queue head, pops on handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (val_o) begin
                if (sb.size() == 0) begin
                    check("spurious_val_o", 32'(val_o), 32'd0);
                end else begin
                    check("dat_c_o", 32'(dat_c_o), 32'(sb[0].quot));
                    check("err_o", 32'(err_o), 32'(sb[0].err));
                    if (rdy_i) void'(sb.pop_front());
                end
            end
            if (val_i && rdy_o) sb.push_back(ref_div(dat_a_i, dat_b_i));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        bit acc;
        acc     = 1'b0;
        val_i   = 1'b1;
        dat_a_i = a;
        dat_b_i = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy_o) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        val_i = 1'b0;
        check("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        bit done;
        done  = 1'b0;
        rdy_i = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !val_o) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        check("drain_done", 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(2);
        rst = 1'b0;
        check("rst_val_o", 32'(val_o), 32'd0);
        check("rst_dat_c_o", 32'(dat_c_o), 32'd0);
        check("rst_err_o", 32'(err_o), 32'd0);
        check("rst_div_a_o", 32'(div_a_o), 32'd0);
        check("rst_div_b_o", 32'(div_b_o), 32'd0);
        check("rst_rdy_o", 32'(rdy_o), 32'd1);

        // Single pair latency: result two edges after the accepting edge
        push_pair(8'd6, 8'd3);
        check("lat_e0_val", 32'(val_o), 32'd0);
        step(1);
        check("lat_e1_val", 32'(val_o), 32'd0);
        check("lat_div_a", 32'(div_a_o), 32'd6);
        check("lat_div_b", 32'(div_b_o), 32'd3);
        step(1);
        check("lat_e2_val", 32'(val_o), 32'd1);
        check("lat_e2_dat", 32'(dat_c_o), 32'h0200);
        check("lat_e2_err", 32'(err_o), 32'd0);
        drain();

        // Fractions and zero divisor followed by a normal pair
        push_pair(8'd1, 8'd3);
        push_pair(8'd255, 8'd1);
        push_pair(8'd7, 8'd0);
        push_pair(8'd4, 8'd2);
        drain();

        // Backpressure: one pair in HOLD plus four buffered fills the stage
        rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
        check("bp_rdy_o_low", 32'(rdy_o), 32'd0);
        step(4);
        check("bp_val_held", 32'(val_o), 32'd1);
        check("bp_rdy_o_still_low", 32'(rdy_o), 32'd0);

        // Full boundary: a pop in the same cycle does not admit the offered pair
        val_i   = 1'b1;
        dat_a_i = 8'h11;
        dat_b_i = 8'h22;
        rdy_i   = 1'b1;
        step(1);
        val_i = 1'b0;
        check("full_pop_rdy_o", 32'(rdy_o), 32'd1);
        check("full_pop_val_o", 32'(val_o), 32'd0);
        drain();

        // Randomized pairs with random downstream stalls
        push_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [7:0] b;
                    b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                    push_pair(8'($urandom_range(0, 255)), b);
                    step(int'($urandom_range(0, 2)));
                end
                push_done = 1'b1;
            end
            begin
                while (!push_done) begin
                    @(posedge clk);
                    #1;
                    rdy_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // Reset while WAIT: the in-flight pair must vanish
        push_pair(8'd50, 8'd7);
        step(1);
        check("wait_div_a", 32'(div_a_o), 32'd50);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_val_o", 32'(val_o), 32'd0);
        check("mid_rst_rdy_o", 32'(rdy_o), 32'd1);
        step(3);
        check("mid_rst_no_result", 32'(val_o), 32'd0);
        push_pair(8'd9, 8'd3);
        drain();

        check("sb_empty_at_end", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
